// File: rtl/bitnet_pkg.sv
// Shared definitions for the up3 ternary-fanout learning block:
// the controller state encoding and the output-width helper.
package bitnet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        FWD_DONE,
        BK_CALC,
        BK_UPDATE,
        BK_DONE
    } state_t;

    // Each input neuron fans out to three output neurons.
    function automatic int out_n(input int n);
        return 3 * n;
    endfunction

endpackage

// File: rtl/unit1to3.sv
// One input neuron and its three output weights. Provides the forward XOR,
// the backward majority vote and the per-weight flip update.
module unit1to3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flip_en,
    input  logic [2:0] flip_mask,
    input  logic       fin_bit,
    input  logic [2:0] bin_grp,
    output logic [2:0] w,
    output logic [2:0] fwd,
    output logic       maj
);

    logic [2:0] bk_bits;

    // Weight register: flips the masked bits when an update is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: weights are few flops, not a RAM, so they take the async reset
        // like any other state; sequential state is always assigned with <=.
        if (!rst_n) begin
            w <= '0;
        end else if (flip_en) begin
            w <= w ^ flip_mask;
        end
    end

    assign fwd     = {3{fin_bit}} ^ w;
    assign bk_bits = bin_grp ^ w;
    assign maj     = (bk_bits[0] & bk_bits[1]) |
                     (bk_bits[0] & bk_bits[2]) |
                     (bk_bits[1] & bk_bits[2]);

endmodule

// File: rtl/up3.sv
// up3: N input neurons, 3*N binary weights. Forward pass XORs inputs into
// the weights; backward pass votes per input, counts output mismatches and
// flips mismatched weights when the oscillator enables the update.
module up3
    import bitnet_pkg::*;
#(
    parameter  int N     = 9,
    localparam int OUT_N = out_n(N),
    localparam int ERR_W = $clog2(OUT_N + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             oscillator,
    input  logic             fd_prop,
    input  logic             bk_prop,
    input  logic [N-1:0]     fin,
    input  logic [OUT_N-1:0] bin,
    output logic             fd_prop_done,
    output logic             bk_prop_done,
    output logic [OUT_N-1:0] fout,
    output logic [N-1:0]     bout,
    output logic [OUT_N-1:0] control_out,
    output logic [ERR_W-1:0] err_count
);

    state_t             state;
    logic [N-1:0]       fin_q;
    logic [OUT_N-1:0]   bin_q;
    logic [OUT_N-1:0]   weights;
    logic [OUT_N-1:0]   fwd_vec;
    logic [OUT_N-1:0]   diff;
    logic [N-1:0]       maj_vec;
    logic [ERR_W-1:0]   mism;
    logic               upd_en;

    assign diff        = bin_q ^ fout;
    assign upd_en      = (state == BK_UPDATE) && oscillator;
    assign control_out = weights;

    for (genvar i = 0; i < N; i++) begin : g_unit
        unit1to3 u_unit (
            .clk       (clk_in),
            .rst_n     (rst_in),
            .flip_en   (upd_en),
            .flip_mask (diff[3*i +: 3]),
            .fin_bit   (fin_q[i]),
            .bin_grp   (bin_q[3*i +: 3]),
            .w         (weights[3*i +: 3]),
            .fwd       (fwd_vec[3*i +: 3]),
            .maj       (maj_vec[i])
        );
    end

    // Mismatch popcount between the captured target and the current fout.
    always_comb begin
        mism = '0;
        for (int j = 0; j < OUT_N; j++) begin
            mism = mism + ERR_W'(diff[j]);
        end
    end

    // Pass controller with registered results and done pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            fin_q        <= '0;
            bin_q        <= '0;
            fout         <= '0;
            bout         <= '0;
            err_count    <= '0;
            fd_prop_done <= 1'b0;
            bk_prop_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Forward has priority; a simultaneous bk_prop is dropped.
                    if (fd_prop) begin
                        fin_q <= fin;
                        state <= FWD;
                    end else if (bk_prop) begin
                        bin_q <= bin;
                        state <= BK_CALC;
                    end
                end
                FWD: begin
                    fout         <= fwd_vec;
                    fd_prop_done <= 1'b1;
                    state        <= FWD_DONE;
                end
                FWD_DONE: begin
                    fd_prop_done <= 1'b0;
                    state        <= IDLE;
                end
                BK_CALC: begin
                    // Uses weights before this pass's update.
                    bout      <= maj_vec;
                    err_count <= mism;
                    state     <= BK_UPDATE;
                end
                BK_UPDATE: begin
                    // Weight flips happen in the units this cycle via upd_en.
                    bk_prop_done <= 1'b1;
                    state        <= BK_DONE;
                end
                BK_DONE: begin
                    bk_prop_done <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up3.sv
// Directed bench for up3 with N=3: a table of passes with hand-computed
// results applied in sequence, plus a hand-written reset-abort sequence.
module tb_up3;

    localparam int N     = 3;
    localparam int OUT_N = 9;
    localparam int ERR_W = 4;

    logic             clk_in;
    logic             rst_in;
    logic             oscillator;
    logic             fd_prop;
    logic             bk_prop;
    logic [N-1:0]     fin;
    logic [OUT_N-1:0] bin;
    logic             fd_prop_done;
    logic             bk_prop_done;
    logic [OUT_N-1:0] fout;
    logic [N-1:0]     bout;
    logic [OUT_N-1:0] control_out;
    logic [ERR_W-1:0] err_count;

    up3 #(.N(N)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .oscillator   (oscillator),
        .fd_prop      (fd_prop),
        .bk_prop      (bk_prop),
        .fin          (fin),
        .bin          (bin),
        .fd_prop_done (fd_prop_done),
        .bk_prop_done (bk_prop_done),
        .fout         (fout),
        .bout         (bout),
        .control_out  (control_out),
        .err_count    (err_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef enum int {OP_RST, OP_FWD, OP_BK, OP_BOTH} op_t;

    typedef struct {
        op_t              op;
        logic [N-1:0]     fin;
        logic [OUT_N-1:0] bin;
        logic             osc;
        logic [3:0]       fd_mask;  // bit k: done seen in cycle t+1+k
        logic [3:0]       bk_mask;
        logic [OUT_N-1:0] fout;
        logic [N-1:0]     bout;
        logic [ERR_W-1:0] err;
        logic [OUT_N-1:0] ctrl;
    } vec_t;

    vec_t vecs[17];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a falling edge; cycle t is the one that follows.
    task automatic run_pass(input vec_t v, input string tag);
        logic [3:0] fdm;
        logic [3:0] bkm;
        fdm = '0;
        bkm = '0;
        if (v.op == OP_RST) begin
            rst_in = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk_in);
                fdm[k] = fd_prop_done;
                bkm[k] = bk_prop_done;
            end
            rst_in = 1'b1;
        end else begin
            fin        = v.fin;
            bin        = v.bin;
            fd_prop    = (v.op != OP_BK);
            bk_prop    = (v.op != OP_FWD);
            oscillator = ~v.osc;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk_in);
                fdm[k] = fd_prop_done;
                bkm[k] = bk_prop_done;
                if (k == 0) begin
                    fd_prop = 1'b0;
                    bk_prop = (v.op == OP_BOTH);  // stray pulse during FWD
                    fin     = ~v.fin;
                    bin     = ~v.bin;
                end else if (k == 1) begin
                    bk_prop    = 1'b0;
                    oscillator = v.osc;           // level seen in BK_UPDATE
                end else begin
                    oscillator = ~v.osc;
                end
            end
            oscillator = 1'b0;
        end
        check({tag, " fd_done_cycles"}, 32'(fdm), 32'(v.fd_mask));
        check({tag, " bk_done_cycles"}, 32'(bkm), 32'(v.bk_mask));
        check({tag, " fout"}, 32'(fout), 32'(v.fout));
        check({tag, " bout"}, 32'(bout), 32'(v.bout));
        check({tag, " err_count"}, 32'(err_count), 32'(v.err));
        check({tag, " control_out"}, 32'(control_out), 32'(v.ctrl));
    endtask

    initial begin
        logic [3:0] fdm;
        logic [3:0] bkm;
        vec_t       hv;

        //          op       fin     bin           osc   fdm      bkm      fout          bout    err  ctrl
        vecs[0]  = '{OP_RST,  3'b000, 9'b000000000, 1'b0, 4'b0000, 4'b0000, 9'b000000000, 3'b000, 4'd0, 9'b000000000};
        vecs[1]  = '{OP_FWD,  3'b101, 9'b000000000, 1'b0, 4'b0010, 4'b0000, 9'b111000111, 3'b000, 4'd0, 9'b000000000};
        vecs[2]  = '{OP_BK,   3'b000, 9'b000000111, 1'b1, 4'b0000, 4'b0100, 9'b111000111, 3'b001, 4'd3, 9'b111000000};
        vecs[3]  = '{OP_FWD,  3'b101, 9'b000000000, 1'b0, 4'b0010, 4'b0000, 9'b000000111, 3'b001, 4'd3, 9'b111000000};
        vecs[4]  = '{OP_BK,   3'b000, 9'b000000111, 1'b1, 4'b0000, 4'b0100, 9'b000000111, 3'b101, 4'd0, 9'b111000000};
        vecs[5]  = '{OP_FWD,  3'b010, 9'b000000000, 1'b0, 4'b0010, 4'b0000, 9'b111111000, 3'b101, 4'd0, 9'b111000000};
        vecs[6]  = '{OP_BK,   3'b000, 9'b101010101, 1'b0, 4'b0000, 4'b0100, 9'b111111000, 3'b001, 4'd5, 9'b111000000};
        vecs[7]  = '{OP_BK,   3'b000, 9'b101010101, 1'b1, 4'b0000, 4'b0100, 9'b111111000, 3'b001, 4'd5, 9'b101101101};
        vecs[8]  = '{OP_FWD,  3'b111, 9'b000000000, 1'b0, 4'b0010, 4'b0000, 9'b010010010, 3'b001, 4'd5, 9'b101101101};
        vecs[9]  = '{OP_BOTH, 3'b000, 9'b111111111, 1'b1, 4'b0010, 4'b0000, 9'b101101101, 3'b001, 4'd5, 9'b101101101};
        vecs[10] = '{OP_BK,   3'b000, 9'b010010010, 1'b1, 4'b0000, 4'b0100, 9'b101101101, 3'b111, 4'd9, 9'b010010010};
        vecs[11] = '{OP_RST,  3'b000, 9'b000000000, 1'b0, 4'b0000, 4'b0000, 9'b000000000, 3'b000, 4'd0, 9'b000000000};
        vecs[12] = '{OP_FWD,  3'b101, 9'b000000000, 1'b0, 4'b0010, 4'b0000, 9'b111000111, 3'b000, 4'd0, 9'b000000000};
        vecs[13] = '{OP_BK,   3'b000, 9'b000000111, 1'b0, 4'b0000, 4'b0100, 9'b111000111, 3'b001, 4'd3, 9'b000000000};
        vecs[14] = '{OP_RST,  3'b000, 9'b000000000, 1'b0, 4'b0000, 4'b0000, 9'b000000000, 3'b000, 4'd0, 9'b000000000};
        vecs[15] = '{OP_BK,   3'b000, 9'b000000111, 1'b1, 4'b0000, 4'b0100, 9'b000000000, 3'b001, 4'd3, 9'b000000111};
        vecs[16] = '{OP_FWD,  3'b101, 9'b000000000, 1'b0, 4'b0010, 4'b0000, 9'b111000000, 3'b001, 4'd3, 9'b000000111};

        rst_in     = 1'b0;
        oscillator = 1'b0;
        fd_prop    = 1'b0;
        bk_prop    = 1'b0;
        fin        = '0;
        bin        = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk_in);
            run_pass(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted while the backward pass sits in BK_CALC.
        @(negedge clk_in);
        bin        = 9'b000000111;
        bk_prop    = 1'b1;
        oscillator = 1'b1;
        @(negedge clk_in);
        bk_prop = 1'b0;
        rst_in  = 1'b0;
        fdm = '0;
        bkm = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            fdm[k] = fd_prop_done;
            bkm[k] = bk_prop_done;
        end
        oscillator = 1'b0;
        check("abort fd_done", 32'(fdm), 32'd0);
        check("abort bk_done", 32'(bkm), 32'd0);
        check("abort control_out", 32'(control_out), 32'd0);
        check("abort fout", 32'(fout), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        check("abort err_count", 32'(err_count), 32'd0);

        // Release and request a forward pass in the very first cycle.
        rst_in = 1'b1;
        hv = '{OP_FWD, 3'b101, 9'b000000000, 1'b0, 4'b0010, 4'b0000, 9'b111000111, 3'b000, 4'd0, 9'b000000000};
        run_pass(hv, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up3.md
UP3 -- requirements
Module: up3

Interface
REQ-001 SHALL have parameter N, default 9, number of input neurons; output width is 3*N.
REQ-002 SHALL have port clk_in, input, 1 bit, the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port oscillator, input, 1 bit, update enable sampled in the UPDATE state.
REQ-005 SHALL have port fd_prop, input, 1 bit, forward-propagation start.
REQ-006 SHALL have port bk_prop, input, 1 bit, backward-propagation start.
REQ-007 SHALL have port fin, input, N bits, forward input activations.
REQ-008 SHALL have port bin, input, 3*N bits, backward target for each output.
REQ-009 SHALL have port fd_prop_done, output, 1 bit, one-cycle forward-complete pulse.
REQ-010 SHALL have port bk_prop_done, output, 1 bit, one-cycle backward-complete pulse.
REQ-011 SHALL have port fout, output, 3*N bits, registered forward result.
REQ-012 SHALL have port bout, output, N bits, registered backward result.
REQ-013 SHALL have port control_out, output, 3*N bits, current weight bits.
REQ-014 SHALL have port err_count, output, clog2(3*N+1) bits, number of mismatched outputs in the last backward pass.

Function
REQ-015 SHALL use an FSM with states IDLE, FWD, FWD_DONE, BK_CALC, BK_UPDATE, BK_DONE.
REQ-016 SHALL leave IDLE only when fd_prop or bk_prop is sampled high; if both are high in the same cycle, forward wins and bk_prop is dropped.
REQ-017 SHALL ignore fd_prop and bk_prop in every state other than IDLE; no queuing.
REQ-018 SHALL, on leaving IDLE for FWD, capture fin into an internal register in that same cycle t.
REQ-019 SHALL, in FWD at cycle t+1, register fout[3i+k] = fin_q[i] XOR w[3i+k] for k=0..2, then go to FWD_DONE.
REQ-020 SHALL hold fd_prop_done high in FWD_DONE (cycle t+2) for exactly one cycle, then return to IDLE.
REQ-021 SHALL, on leaving IDLE for BK_CALC, capture bin in cycle t.
REQ-022 SHALL, in BK_CALC at cycle t+1, register bout[i] = majority over k of (bin_q[3i+k] XOR w[3i+k]), computed with pre-update weights.
REQ-023 SHALL, in BK_CALC, register err_count = popcount(bin_q XOR fout) against the current fout register, saturating-free since width holds 3*N.
REQ-024 SHALL, in BK_UPDATE at cycle t+2, flip w[j] for every j where bin_q[j] != fout[j], but only if oscillator is high in that cycle; otherwise weights are unchanged.
REQ-025 SHALL hold bk_prop_done high in BK_DONE (cycle t+3) for exactly one cycle, then return to IDLE.
REQ-026 SHALL keep fout, bout and err_count stable outside the state that writes them.
REQ-027 SHALL drive control_out directly from the weight register, reflecting updates from the cycle after BK_UPDATE.
REQ-028 SHALL treat a backward pass before any forward pass as valid, comparing against the reset fout of all zeros.

Reset
REQ-029 SHALL, while rst_in is low, force state to IDLE, all weights to 0, fout to 0, bout to 0, err_count to 0, both done outputs to 0, and the input capture registers to 0.
REQ-030 SHALL abort any pass in progress on reset with no done pulse; a pass interrupted before BK_UPDATE leaves no weight change.

Structure
REQ-031 SHALL place the FSM state enum and an OUT_N = 3*N width helper in the shared bitnet package.
REQ-032 SHALL implement one sub-module, unit1to3, instantiated N times, holding 3 weight bits and the per-group XOR, majority and flip logic; the FSM and popcount stay in up3.

Verification
REQ-033 SHALL verify, with N=3: after reset, fd_prop with fin=3'b101 -> fout=9'b111000111 and fd_prop_done high in exactly cycle t+2.
REQ-034 SHALL verify: bk_prop with bin=9'b000000111, fout=9'b111000111, oscillator=1 -> err_count=3, bout=3'b001, control_out=9'b111000000, and bk_prop_done high in cycle t+3.
REQ-035 SHALL verify: the same backward pass with oscillator=0 in BK_UPDATE -> control_out stays 0, and err_count and bout are as in REQ-034.
REQ-036 SHALL verify: fd_prop and bk_prop both high in the same cycle -> forward pass only, no bk_prop_done pulse; a pulse asserted during FWD is ignored.
REQ-037 SHALL verify: rst_in driven low in BK_CALC -> no done pulse, weights and outputs are 0, and the FSM accepts fd_prop on the first cycle after release.
